droute_pack_switch: RTL



---
 rtl/droute_pack_switch.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/droute_pack_switch.sv
`default_nettype none
// ============================================================================
// Module   : droute_pack_switch
// Purpose  : Packs RATIO narrow beats of S_WIDTH bits into one wide word and
//            steers each word to one of N_OUT AXI-stream channels, as chosen
//            by a per-transfer command (destination, word count). A
//            completion pulse is raised when the last word has left.
// Revision : 1.0  initial release
// ============================================================================
module droute_pack_switch #(
    parameter int S_WIDTH = 128,
    parameter int RATIO   = 12,
    parameter int N_OUT   = 3,
    parameter int CNT_W   = 16,
    localparam int M_WIDTH = S_WIDTH * RATIO,
    localparam int DEST_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DEST_W-1:0]  s_cfg_dest,
    input  logic [CNT_W-1:0]   s_cfg_count,
    input  logic               s_cfg_valid,
    output logic               s_cfg_ready,
    input  logic [S_WIDTH-1:0] s_in_tdata,
    input  logic               s_in_tvalid,
    output logic               s_in_tready,
    output logic [M_WIDTH-1:0] m_out_tdata,
    output logic [N_OUT-1:0]   m_out_tvalid,
    input  logic [N_OUT-1:0]   m_out_tready,
    output logic               count_tvalid,
    output logic               busy,
    output logic               err_dest
);

    localparam int IDX_W = $clog2(RATIO);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FILL  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [DEST_W-1:0]  r_dest;
    logic               r_dest_bad;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_wcnt;
    logic [M_WIDTH-1:0] r_pack;
    logic [IDX_W-1:0]   r_idx;
    logic               r_pack_full;
    logic [M_WIDTH-1:0] r_out_data;
    logic               r_out_full;
    logic               r_count_pulse;
    logic               r_err;

    logic               w_cfg_hs;
    logic               w_cfg_bad;
    logic               w_beat_acc;
    logic               w_last_beat;
    logic               w_fire;
    logic               w_out_free;
    logic               w_move;
    logic               w_final_word;
    logic               w_last_word;
    logic [N_OUT-1:0]   w_tvalid;
    logic [M_WIDTH-1:0] w_pack_wr;
    logic [M_WIDTH-1:0] w_move_data;

    assign w_cfg_hs    = s_cfg_valid & s_cfg_ready;
    assign w_cfg_bad   = (32'(s_cfg_dest) >= 32'(N_OUT));
    assign w_beat_acc  = s_in_tvalid & s_in_tready;
    assign w_last_beat = w_beat_acc & (r_idx == IDX_W'(RATIO - 1));

    // A word bound for a nonexistent channel is dropped as soon as it lands
    // in the output register, so the transfer still runs to completion.
    assign w_fire     = r_out_full & (r_dest_bad | (|(w_tvalid & m_out_tready)));
    assign w_out_free = ~r_out_full | w_fire;

    // The word being completed (or held in the pack register) is the last one.
    assign w_final_word = ((r_wcnt + CNT_W'(1)) == r_count);
    assign w_move       = (r_pack_full | w_last_beat) & w_out_free;
    assign w_last_word  = w_move & w_final_word;

    generate
        for (genvar i = 0; i < N_OUT; i++) begin : g_tvalid
            assign w_tvalid[i] = r_out_full & ~r_dest_bad & (r_dest == DEST_W'(i));
        end
    endgenerate

    // Pack register image with the incoming beat merged into its slot.
    always_comb begin
        w_pack_wr = r_pack;
        for (int k = 0; k < RATIO; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_pack_wr[k*S_WIDTH +: S_WIDTH] = s_in_tdata;
            end
        end
        w_move_data = r_pack_full ? r_pack : w_pack_wr;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a zero-length command never leaves IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_cfg_hs && (s_cfg_count != '0)) begin
                    w_state_nxt = c_FILL;
                end
            end
            c_FILL: begin
                if (w_last_word) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_fire) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Handshake outputs: input stalls only when a completed word is stuck
    // in the pack register, or when it is the final word (no more beats due).
    always_comb begin
        s_cfg_ready = (r_state == c_IDLE);
        busy        = (r_state != c_IDLE);
        s_in_tready = (r_state == c_FILL) &
                      ~(r_pack_full & (~w_out_free | w_final_word));
    end

    // Datapath: command latch, beat packing, output register, word counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dest        <= '0;
            r_dest_bad    <= 1'b0;
            r_count       <= '0;
            r_wcnt        <= '0;
            r_pack        <= '0;
            r_idx         <= '0;
            r_pack_full   <= 1'b0;
            r_out_data    <= '0;
            r_out_full    <= 1'b0;
            r_count_pulse <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_count_pulse <= 1'b0;

            if (w_cfg_hs) begin
                r_dest     <= s_cfg_dest;
                r_dest_bad <= w_cfg_bad;
                r_count    <= s_cfg_count;
                r_wcnt     <= '0;
                r_idx      <= '0;
                if (w_cfg_bad) begin
                    r_err <= 1'b1;
                end
                if (s_cfg_count == '0) begin
                    r_count_pulse <= 1'b1;
                end
            end

            if ((r_state == c_DRAIN) && w_fire) begin
                r_count_pulse <= 1'b1;
            end

            if (w_beat_acc) begin
                r_pack <= w_pack_wr;
                r_idx  <= (r_idx == IDX_W'(RATIO - 1)) ? '0 : r_idx + IDX_W'(1);
            end

            if (w_move) begin
                r_pack_full <= 1'b0;
            end else if (w_last_beat) begin
                r_pack_full <= 1'b1;
            end

            if (w_move) begin
                r_out_data <= w_move_data;
                r_out_full <= 1'b1;
                r_wcnt     <= r_wcnt + CNT_W'(1);
            end else if (w_fire) begin
                r_out_full <= 1'b0;
            end
        end
    end

    assign m_out_tdata  = r_out_data;
    assign m_out_tvalid = w_tvalid;
    assign count_tvalid = r_count_pulse;
    assign err_dest     = r_err;

endmodule
`default_nettype wire
